// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and types.
// Imported by the axis counter and the timing generator top.
package vga_timing_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;

    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int CNT_W_D    = 10;

    function automatic int axis_total(
        input int act,
        input int fp,
        input int syn,
        input int bp
    );
        return act + fp + syn + bp;
    endfunction

    localparam int H_TOTAL_D =
        axis_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
    localparam int V_TOTAL_D =
        axis_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } hphase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis with carry-out and
// active/sync window decode of the next count value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W        = CNT_W_D,
    parameter int ACT_LEN  = H_ACTIVE_D,
    parameter int FP_LEN   = H_FP_D,
    parameter int SYNC_LEN = H_SYNC_D,
    parameter int BP_LEN   = H_BP_D
) (
    input  logic         clk_50mhz,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] nxt,
    output logic         carry,
    output logic         act_nxt,
    output logic         sync_nxt
);

    localparam int TOTAL =
        axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACT_LEN);
    localparam logic [W-1:0] SYN_LO  = W'(ACT_LEN + FP_LEN);
    localparam logic [W-1:0] SYN_HI  =
        W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);

    logic [W-1:0] cnt;

    // Next count, wrap carry and window decode of the next value.
    always_comb begin
        nxt   = cnt;
        carry = 1'b0;
        if (en) begin
            if (cnt == LAST) begin
                nxt   = '0;
                carry = 1'b1;
            end else begin
                nxt = cnt + 1'b1;
            end
        end
        act_nxt  = (nxt < ACT_END);
        sync_nxt = (nxt >= SYN_LO) && (nxt <= SYN_HI);
    end

    // Count register; resets to the last position so the first
    // enable lands on zero.
    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            cnt <= LAST;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator advanced by a pixel enable.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_D,
    parameter int H_FP      = H_FP_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BP      = H_BP_D,
    parameter int V_ACTIVE  = V_ACTIVE_D,
    parameter int V_FP      = V_FP_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BP      = V_BP_D,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = CNT_W_D
) (
    input  logic             clk_50mhz,
    input  logic             reset_n,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam logic [CNT_W-1:0] HX_FRONT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HX_SYNC  =
        CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HX_BACK  =
        CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_carry;
    logic             v_carry;
    logic             h_act;
    logic             h_sync;
    logic             v_act;
    logic             v_sync;
    hphase_t          phase_q;
    hphase_t          phase_d;

    vga_axis_counter #(
        .W        (CNT_W),
        .ACT_LEN  (H_ACTIVE),
        .FP_LEN   (H_FP),
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP)
    ) u_h (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .en        (pix_en),
        .nxt       (h_nxt),
        .carry     (h_carry),
        .act_nxt   (h_act),
        .sync_nxt  (h_sync)
    );

    // Vertical steps once per horizontal wrap, so vsync and
    // its carry only move on line boundaries.
    vga_axis_counter #(
        .W        (CNT_W),
        .ACT_LEN  (V_ACTIVE),
        .FP_LEN   (V_FP),
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP)
    ) u_v (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .en        (h_carry),
        .nxt       (v_nxt),
        .carry     (v_carry),
        .act_nxt   (v_act),
        .sync_nxt  (v_sync)
    );

    // Horizontal phase state register.
    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            phase_q <= BACK;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase transitions keyed on the next horizontal count.
    always_comb begin
        phase_d = phase_q;
        if (pix_en) begin
            unique case (phase_q)
                ACTIVE:  if (h_nxt == HX_FRONT) phase_d = FRONT;
                FRONT:   if (h_nxt == HX_SYNC)  phase_d = SYNC;
                SYNC:    if (h_nxt == HX_BACK)  phase_d = BACK;
                BACK:    if (h_carry)           phase_d = ACTIVE;
                default: phase_d = BACK;
            endcase
        end
    end

    // Registered outputs decoded from the next counter values.
    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_carry;
            frame_start <= v_carry;
            if (pix_en) begin
                pixel_x  <= h_nxt;
                pixel_y  <= v_nxt;
                video_on <= (phase_d == ACTIVE) && v_act;
                hsync    <= (phase_d == SYNC) ? HSYNC_POL
                                              : ~HSYNC_POL;
                vsync    <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Frame counter bumps with every frame_start, wrapping at 16 bits.
    always_ff @(posedge clk_50mhz) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (v_carry) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

    phase_matches_h: assert property (
        @(posedge clk_50mhz) disable iff (!reset_n)
        ((phase_d == ACTIVE) == h_act) &&
        ((phase_d == SYNC) == h_sync) &&
        ((phase_d == FRONT) == (!h_act && h_nxt < HX_SYNC))
    );

endmodule
